// File: rtl/spi_adc_if.sv
// SPI pin bundle between an ADC-reading master and the emulated ADC responder.
interface spi_adc_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sck, output cs, output mosi, input miso, input miso_oe);
    modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave emulating a 12-bit 2-channel ADC: start bit, SGL/ODD/MSBF config,
// null bit, sample MSB-first with optional LSB-first replay, then zeros until CS rises.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    spi_adc_if.slave          spi,
    input  logic [DATA_W-1:0] ch0_data_i,
    input  logic [DATA_W-1:0] ch1_data_i,
    output logic              busy_o,
    output logic              sample_strobe_o,
    output logic              cfg_sgl_o,
    output logic              cfg_odd_o,
    output logic              frame_err_o
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONFIG   = 3'd1,
        S_NULL     = 3'd2,
        S_DATA_MSB = 3'd3,
        S_DATA_LSB = 3'd4,
        S_TAIL     = 3'd5
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sck_prev_q, armed_q;
    logic                   sck_s, cs_s, mosi_s, sck_rise_s, sck_fall_s;
    logic                   abort_s, start_s, active_s;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d, cfg_sh_q, cfg_sh_d;
    logic                msbf_q, msbf_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
    logic                strobe_q, strobe_d, sgl_q, sgl_d, odd_q, odd_d, ferr_q, ferr_d;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign abort_s    = cs_s | ~ena_i;
    assign start_s    = sck_rise_s & mosi_s & armed_q;
    assign active_s   = state_q inside {S_CONFIG, S_NULL, S_DATA_MSB, S_DATA_LSB};

    // Pin synchronizers; armed_q only sets once a real (post-reset) CS high has been seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            fill_q      <= {SYNC_STAGES{1'b0}};
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_s;
            armed_q     <= armed_q | (cs_s & fill_q[SYNC_STAGES-1]);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            cfg_sh_q <= 2'd0;
            msbf_q   <= 1'b0;
            shadow_q <= {DATA_W{1'b0}};
            idx_q    <= IDX_ZERO;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            sgl_q    <= 1'b0;
            odd_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_sh_q <= cfg_sh_d;
            msbf_q   <= msbf_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            sgl_q    <= sgl_d;
            odd_q    <= odd_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic; a deasserted frame (CS high or ena low) wins over any SCK edge.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (start_s) state_d = S_CONFIG; else state_d = S_IDLE;
                S_CONFIG:   if (sck_rise_s && cnt_q == 2'd2) state_d = S_NULL; else state_d = S_CONFIG;
                S_NULL:     if (sck_fall_s) state_d = S_DATA_MSB; else state_d = S_NULL;
                S_DATA_MSB: begin
                    if (sck_fall_s && idx_q == IDX_ZERO) begin
                        if (msbf_q) state_d = S_TAIL; else state_d = S_DATA_LSB;
                    end else begin
                        state_d = S_DATA_MSB;
                    end
                end
                S_DATA_LSB: if (sck_fall_s && idx_q == IDX_MAX) state_d = S_TAIL; else state_d = S_DATA_LSB;
                S_TAIL:     state_d = S_TAIL;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d    = cnt_q;
        cfg_sh_d = cfg_sh_q;
        msbf_d   = msbf_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        sgl_d    = sgl_q;
        odd_d    = odd_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        if (abort_s) begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
            busy_d = 1'b0;
            cnt_d  = 2'd0;
            ferr_d = ena_i & cs_s & active_s;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        busy_d = 1'b1;
                        cnt_d  = 2'd0;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                S_CONFIG: begin
                    if (sck_rise_s) begin
                        cfg_sh_d = {cfg_sh_q[0], mosi_s};
                        cnt_d    = cnt_q + 2'd1;
                        // Third config bit: cfg_sh_q already holds {SGL, ODD}, MOSI is MSBF.
                        if (cnt_q == 2'd2) begin
                            sgl_d    = cfg_sh_q[1];
                            odd_d    = cfg_sh_q[0];
                            msbf_d   = mosi_s;
                            shadow_d = cfg_sh_q[0] ? ch1_data_i : ch0_data_i;
                            strobe_d = 1'b1;
                        end else begin
                            strobe_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_NULL: begin
                    if (sck_fall_s) begin
                        oe_d   = 1'b1;
                        miso_d = 1'b0;
                        idx_d  = IDX_MAX;
                    end else begin
                        idx_d = idx_q;
                    end
                end
                S_DATA_MSB: begin
                    if (sck_fall_s) begin
                        miso_d = shadow_q[idx_q];
                        idx_d  = (idx_q == IDX_ZERO) ? IDX_ONE : (idx_q - IDX_ONE);
                    end else begin
                        idx_d = idx_q;
                    end
                end
                S_DATA_LSB: begin
                    if (sck_fall_s) begin
                        miso_d = shadow_q[idx_q];
                        idx_d  = (idx_q == IDX_MAX) ? idx_q : (idx_q + IDX_ONE);
                    end else begin
                        idx_d = idx_q;
                    end
                end
                S_TAIL: begin
                    if (sck_fall_s) miso_d = 1'b0; else miso_d = miso_q;
                end
                default: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign spi.miso        = miso_q;
    assign spi.miso_oe     = oe_q;
    assign busy_o          = busy_q;
    assign sample_strobe_o = strobe_q;
    assign cfg_sgl_o       = sgl_q;
    assign cfg_odd_o       = odd_q;
    assign frame_err_o     = ferr_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Scoreboard bench: a frame-level ADC model queues expected MISO bits and configs,
// independent monitors pop and compare when the DUT drives MISO or strobes a sample.
module tb_spi_adc_responder;
    localparam int DATA_W = 12;
    localparam int SYNC   = 2;
    localparam int H      = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [DATA_W-1:0] ch0, ch1;
    logic              busy, strobe, sgl, odd, ferr;

    spi_adc_if spi ();

    spi_adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena_i           (ena),
        .spi             (spi),
        .ch0_data_i      (ch0),
        .ch1_data_i      (ch1),
        .busy_o          (busy),
        .sample_strobe_o (strobe),
        .cfg_sgl_o       (sgl),
        .cfg_odd_o       (odd),
        .frame_err_o     (ferr)
    );

    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_err = 0;
    int       strobe_cnt = 0;
    int       ferr_cyc = 0;
    bit       exp_miso_q[$];
    bit [1:0] exp_cfg_q[$];
    bit       miso_exp;
    bit [1:0] cfg_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Master samples MISO on SCK rise whenever the slave claims the line.
    always @(posedge spi.sck) begin
        if (spi.cs === 1'b0 && spi.miso_oe === 1'b1) begin
            if (exp_miso_q.size() == 0) begin
                check("miso_unexpected_drive", 32'(spi.miso_oe), 32'd0);
            end else begin
                miso_exp = exp_miso_q.pop_front();
                check("miso_bit", 32'(spi.miso), 32'(miso_exp));
            end
        end
    end

    // Sample strobes carry the decoded config; frame_err high cycles are tallied.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (strobe === 1'b1) begin
                strobe_cnt++;
                if (exp_cfg_q.size() == 0) begin
                    check("strobe_unexpected", 32'(strobe), 32'd0);
                end else begin
                    cfg_exp = exp_cfg_q.pop_front();
                    check("cfg_sgl_odd", 32'({sgl, odd}), 32'(cfg_exp));
                end
            end
            if (ferr === 1'b1) ferr_cyc++;
        end
    end

    // One master frame: model first, then drive. ena_off_at = rise number at which ena drops (0 = never).
    task automatic run_frame(input logic [15:0] pre, input int npre, input int cycles,
                             input int ena_off_at, input bit chg,
                             input logic [DATA_W-1:0] new0, input logic [DATA_W-1:0] new1);
        bit                mb[64];
        int                s, k, en_lim, j, f, exp_err, exp_str, err0, str0;
        bit                c_sgl, c_odd, c_msbf, exp_busy;
        logic [DATA_W-1:0] smp;
        for (int r = 1; r <= cycles; r++)
            mb[r] = (r <= npre) ? pre[npre - r] : 1'($urandom_range(1, 0));
        s = cycles + 1;
        for (int r = cycles; r >= 1; r--)
            if (mb[r]) s = r;
        for (int r = 1; r <= 3; r++) if (s + r > cycles) mb[s + r] = 1'b0;
        k      = s + 3;
        c_sgl  = mb[s + 1];
        c_odd  = mb[s + 2];
        c_msbf = mb[s + 3];
        smp    = c_odd ? ch1 : ch0;
        en_lim = (ena_off_at == 0) ? cycles + 1 : ena_off_at;
        exp_str = 0;
        if (k <= cycles && k < en_lim) begin
            exp_cfg_q.push_back({c_sgl, c_odd});
            exp_str = 1;
        end
        for (int r = k + 1; r <= cycles && r < en_lim; r++) begin
            j = r - k - 1;
            if (j == 0)                     exp_miso_q.push_back(1'b0);
            else if (j <= DATA_W)           exp_miso_q.push_back(smp[DATA_W - j]);
            else if (!c_msbf && j <= 2 * DATA_W - 1) exp_miso_q.push_back(smp[j - DATA_W]);
            else                            exp_miso_q.push_back(1'b0);
        end
        exp_err = 0;
        if (ena_off_at == 0 && s <= cycles) begin
            f = cycles - k + 1;
            if (cycles < k) exp_err = 1;
            else exp_err = (f < (c_msbf ? DATA_W + 1 : 2 * DATA_W)) ? 1 : 0;
        end
        exp_busy = (s <= cycles) && (ena_off_at == 0);

        err0 = ferr_cyc;
        str0 = strobe_cnt;
        spi.cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int r = 1; r <= cycles; r++) begin
            if (r == ena_off_at) ena = 1'b0;
            spi.mosi = mb[r];
            repeat (H) @(negedge clk);
            spi.sck = 1'b1;
            repeat (4) @(negedge clk);
            if (chg && r == k) begin
                ch0 = new0;
                ch1 = new1;
            end
            repeat (H - 4) @(negedge clk);
            spi.sck = 1'b0;
        end
        repeat (H) @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'(exp_busy));
        spi.cs = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        check("miso_oe_after_cs", 32'(spi.miso_oe), 32'd0);
        check("busy_after_cs", 32'(busy), 32'd0);
        repeat (H) @(negedge clk);
        check("frame_err_cycles", 32'(ferr_cyc - err0), 32'(exp_err));
        check("strobe_count", 32'(strobe_cnt - str0), 32'(exp_str));
        ena = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        int z;
        int cyc;
        rst_n    = 1'b0;
        ena      = 1'b1;
        spi.cs   = 1'b0;
        spi.sck  = 1'b0;
        spi.mosi = 1'b1;
        ch0      = 12'h000;
        ch1      = 12'h000;

        // Reset with CS low and SCK toggling.
        repeat (4) begin
            @(negedge clk);
            check("reset_miso_oe", 32'(spi.miso_oe), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_strobe", 32'(strobe), 32'd0);
            spi.sck = ~spi.sck;
        end
        check("reset_cfg", 32'({sgl, odd, ferr}), 32'd0);
        rst_n = 1'b1;
        // CS never seen high since reset: start bits must be ignored.
        repeat (8) begin
            repeat (H) @(negedge clk);
            spi.sck = ~spi.sck;
        end
        check("no_start_before_cs_high", 32'(busy), 32'd0);
        spi.sck = 1'b0;
        spi.cs  = 1'b1;
        repeat (2 * H) @(negedge clk);

        ch0 = 12'hA5C;
        run_frame(16'b1101, 4, 17, 0, 1'b0, 12'h000, 12'h000);
        ch1 = 12'h3C1;
        run_frame(16'b1110, 4, 31, 0, 1'b0, 12'h000, 12'h000);
        ch0 = 12'h800;
        run_frame(16'b0001101, 7, 20, 0, 1'b1, 12'hFFF, ch1);
        ch0 = 12'h5A5;
        run_frame(16'b1101, 4, 10, 0, 1'b0, 12'h000, 12'h000);
        ch0 = 12'h123;
        run_frame(16'b1101, 4, 17, 0, 1'b0, 12'h000, 12'h000);
        run_frame(16'b1100, 4, 14, 8, 1'b0, 12'h000, 12'h000);
        run_frame(16'b1110, 4, 17, 1, 1'b0, 12'h000, 12'h000);
        run_frame(16'b1101, 4, 17, 0, 1'b0, 12'h000, 12'h000);

        for (int i = 0; i < 12; i++) begin
            z   = int'($urandom_range(3, 0));
            ch0 = 12'($urandom);
            ch1 = 12'($urandom);
            cyc = int'($urandom_range(z + 4 + 28, z + 1));
            run_frame(16'(8 + $urandom_range(7, 0)), z + 4, cyc, 0, 1'b1,
                      12'($urandom), 12'($urandom));
        end

        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
        check("cfg_queue_drained", 32'(exp_cfg_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
